noc_vc_credit_arbiter: RTL

NOC_VC_CREDIT_ARBITER -- requirements
Module: noc_vc_credit_arbiter

---
 rtl/common_pkg.sv | 11 +
 rtl/noc_vc_credit_arbiter_if.sv | 41 ++++
 rtl/rr_arbiter.sv | 33 +++
 rtl/noc_vc_credit_arbiter.sv | 115 +++++++++++
 4 files changed

// File: rtl/common_pkg.sv
// common_pkg -- shared NoC defaults used across the switch fabric.
//   A_W                   : address field width of a flit
//   DEFAULT_D_W           : data field width of a flit
//   DEFAULT_VC_W          : number of virtual channels (one-hot VC width)
//   DEFAULT_VC_FIFO_DEPTH : downstream per-VC FIFO depth
package common_pkg;
    localparam int A_W                   = 8;
    localparam int DEFAULT_D_W           = 16;
    localparam int DEFAULT_VC_W          = 2;
    localparam int DEFAULT_VC_FIFO_DEPTH = 4;
endpackage

// File: rtl/noc_vc_credit_arbiter_if.sv
// noc_vc_credit_arbiter_if -- requester, downstream and status signals of one
// switch output port.
//   req_vc        : per-requester one-hot VC request (all-zero = idle)
//   req_packet    : per-requester opaque packet
//   req_gnt       : one-hot acceptance of a requester's packet this cycle
//   tx_vc         : registered one-hot VC of the forwarded packet (0 = none)
//   tx_packet     : registered forwarded packet
//   tx_credit_gnt : downstream credit return, one credit per set bit per cycle
//   credit_avail  : bit v high while VC v holds at least one credit
//   err_credit_ovf, err_multihot : sticky error flags
// Handshake: a requester raises req_vc and holds req_vc/req_packet stable
// until it sees its req_gnt bit high; the packet is transferred in that cycle
// and appears on tx_vc/tx_packet one cycle later.
// Modports: slave = arbiter side, master = requesters/downstream side.
interface noc_vc_credit_arbiter_if
    import common_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int VC_W    = DEFAULT_VC_W,
    parameter int PKT_W   = A_W + DEFAULT_D_W
);
    logic [NUM_REQ*VC_W-1:0]  req_vc;
    logic [NUM_REQ*PKT_W-1:0] req_packet;
    logic [NUM_REQ-1:0]       req_gnt;
    logic [VC_W-1:0]          tx_vc;
    logic [PKT_W-1:0]         tx_packet;
    logic [VC_W-1:0]          tx_credit_gnt;
    logic [VC_W-1:0]          credit_avail;
    logic                     err_credit_ovf;
    logic                     err_multihot;

    modport slave (
        input  req_vc, req_packet, tx_credit_gnt,
        output req_gnt, tx_vc, tx_packet, credit_avail, err_credit_ovf, err_multihot
    );

    modport master (
        output req_vc, req_packet, tx_credit_gnt,
        input  req_gnt, tx_vc, tx_packet, credit_avail, err_credit_ovf, err_multihot
    );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter -- rotating-priority picker.
//   eligible : requesters that may be granted this cycle
//   rr_ptr   : index with highest priority; search order rr_ptr, rr_ptr+1, ...
//   grant    : one-hot pick (all-zero when nothing is eligible)
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant
);
    int   idx;
    logic found;

    // Walk offsets from the pointer; the inner loop keeps every bit select
    // constant so the picker unrolls into plain priority logic.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && (i == idx) && eligible[i]) begin
                    grant[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/noc_vc_credit_arbiter.sv
// noc_vc_credit_arbiter -- shares one switch output port among NUM_REQ
// requesters with per-VC credit flow control toward the downstream FIFOs.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : noc_vc_credit_arbiter_if.slave (requests, grants, forwarded packet,
//         credit returns, credit status, sticky errors)
// Each VC holds VC_FIFO_DEPTH-1 credits after reset. A requester is eligible
// when its VC request is exactly one-hot and that VC's registered counter is
// non-zero; returned credits only become usable on the following cycle.
module noc_vc_credit_arbiter
    import common_pkg::*;
#(
    parameter int NUM_REQ       = 3,
    parameter int VC_W          = DEFAULT_VC_W,
    parameter int VC_FIFO_DEPTH = DEFAULT_VC_FIFO_DEPTH,
    parameter int PKT_W         = A_W + DEFAULT_D_W
) (
    input  logic                     clk,
    input  logic                     rst,
    noc_vc_credit_arbiter_if.slave   bus
);
    localparam int CNT_W = $clog2(VC_FIFO_DEPTH);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(VC_FIFO_DEPTH - 1);

    logic [CNT_W-1:0]   cnt_q [VC_W];
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   next_ptr;
    logic [VC_W-1:0]    credit_avail;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] lane_multihot;
    logic [NUM_REQ-1:0] gnt;
    logic [VC_W-1:0]    sent_vc;
    logic [PKT_W-1:0]   gnt_pkt;
    logic [VC_W-1:0]    tx_vc_q;
    logic [PKT_W-1:0]   tx_packet_q;
    logic               err_ovf_q;
    logic               err_mh_q;

    always_comb begin
        credit_avail = '0;
        for (int v = 0; v < VC_W; v++) credit_avail[v] = (cnt_q[v] != '0);
    end

    // Gating with rst keeps req_gnt low for the whole reset pulse, so packets
    // pending at reset are never accepted.
    always_comb begin
        eligible      = '0;
        lane_multihot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            lane_multihot[i] = (bus.req_vc[i*VC_W +: VC_W] != '0) &&
                               !$onehot(bus.req_vc[i*VC_W +: VC_W]);
            eligible[i]      = !rst && $onehot(bus.req_vc[i*VC_W +: VC_W]) &&
                               |(bus.req_vc[i*VC_W +: VC_W] & credit_avail);
        end
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .eligible (eligible),
        .rr_ptr   (rr_ptr),
        .grant    (gnt)
    );

    // Route the winner's VC and packet; the pointer moves just past the winner.
    always_comb begin
        sent_vc  = '0;
        gnt_pkt  = '0;
        next_ptr = rr_ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sent_vc  = bus.req_vc[i*VC_W +: VC_W];
                gnt_pkt  = bus.req_packet[i*PKT_W +: PKT_W];
                next_ptr = PTR_W'((i + 1) % NUM_REQ);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < VC_W; v++) cnt_q[v] <= CNT_MAX;
            rr_ptr      <= '0;
            tx_vc_q     <= '0;
            tx_packet_q <= '0;
            err_ovf_q   <= 1'b0;
            err_mh_q    <= 1'b0;
        end else begin
            rr_ptr  <= next_ptr;
            tx_vc_q <= sent_vc;
            if (|sent_vc) tx_packet_q <= gnt_pkt;
            // Send and return on the same VC cancel out. A send implies a
            // non-zero count, so the decrement cannot underflow.
            for (int v = 0; v < VC_W; v++) begin
                case ({sent_vc[v], bus.tx_credit_gnt[v]})
                    2'b10: cnt_q[v] <= cnt_q[v] - CNT_W'(1);
                    2'b01: begin
                        if (cnt_q[v] == CNT_MAX) err_ovf_q <= 1'b1;
                        else                     cnt_q[v] <= cnt_q[v] + CNT_W'(1);
                    end
                    default: ;
                endcase
            end
            if (|lane_multihot) err_mh_q <= 1'b1;
        end
    end

    assign bus.req_gnt        = gnt;
    assign bus.tx_vc          = tx_vc_q;
    assign bus.tx_packet      = tx_packet_q;
    assign bus.credit_avail   = credit_avail;
    assign bus.err_credit_ovf = err_ovf_q;
    assign bus.err_multihot   = err_mh_q;
endmodule
